// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep sequencer: ramps count between latched limits with dwell at each turn.
// Optional continuous mode (passes=0 repeats forever) when UPDOWN_SWEEP_CONT_EN is defined.
module updown_sweep_ctrl #(
   parameter int WIDTH   = 4,
   parameter int PASS_W  = 4,
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [WIDTH-1:0]   lo_lim,
   input  logic [WIDTH-1:0]   hi_lim,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [PASS_W-1:0]  passes,
   output logic [WIDTH-1:0]   count,
   output logic               up_down,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [PASS_W-1:0]  pass_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_UP      = 3'd1,
      S_HOLD_HI = 3'd2,
      S_DOWN    = 3'd3,
      S_HOLD_LO = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   lo_r, hi_r;
   logic [DWELL_W-1:0] dwell_r, timer, timer_nxt;
   logic [PASS_W-1:0]  passes_r, pass_cnt_nxt;
   logic [WIDTH-1:0]   count_nxt;
   logic               up_down_nxt;
   logic               busy_nxt, done_nxt, err_nxt;
   logic               load, reject, last_pass, timer_end;
   logic [WIDTH-1:0]   cnt_inc, cnt_dec;
   logic [PASS_W-1:0]  pass_inc;

   assign cnt_inc   = count + 1'b1;
   assign cnt_dec   = count - 1'b1;
   assign pass_inc  = pass_cnt + 1'b1;
   assign timer_end = (timer == DWELL_W'(1)) || (timer == '0);

`ifdef UPDOWN_SWEEP_CONT_EN
   logic cont_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cont_r <= 1'b0;
      else if (load)
         cont_r <= (passes == '0);
   end

   assign last_pass = !cont_r && (pass_inc == passes_r);
`else
   assign last_pass = (pass_inc == passes_r);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         count    <= '0;
         up_down  <= 1'b1;
         pass_cnt <= '0;
         timer    <= '0;
         lo_r     <= '0;
         hi_r     <= '0;
         dwell_r  <= '0;
         passes_r <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         up_down  <= up_down_nxt;
         pass_cnt <= pass_cnt_nxt;
         timer    <= timer_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
         if (load) begin
            lo_r     <= lo_lim;
            hi_r     <= hi_lim;
            dwell_r  <= dwell;
            passes_r <= (passes == '0) ? PASS_W'(1) : passes;
         end
      end
   end

   // stop is checked first in every active state so it beats any same-edge transition
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      up_down_nxt  = up_down;
      pass_cnt_nxt = pass_cnt;
      timer_nxt    = timer;
      load         = 1'b0;
      reject       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (lo_lim >= hi_lim) begin
                  reject = 1'b1;
               end else begin
                  load         = 1'b1;
                  state_nxt    = S_UP;
                  count_nxt    = lo_lim;
                  pass_cnt_nxt = '0;
                  up_down_nxt  = 1'b1;
                  timer_nxt    = '0;
               end
            end
         end
         S_UP: begin
            if (stop) begin
               state_nxt = S_IDLE;
            end else begin
               count_nxt = cnt_inc;
               if (cnt_inc == hi_r) begin
                  if (dwell_r != '0) begin
                     state_nxt = S_HOLD_HI;
                     timer_nxt = dwell_r;
                  end else begin
                     state_nxt   = S_DOWN;
                     up_down_nxt = 1'b0;
                  end
               end
            end
         end
         S_HOLD_HI: begin
            if (stop) begin
               state_nxt = S_IDLE;
            end else if (timer_end) begin
               state_nxt   = S_DOWN;
               up_down_nxt = 1'b0;
               timer_nxt   = '0;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         S_DOWN: begin
            if (stop) begin
               state_nxt = S_IDLE;
            end else begin
               count_nxt = cnt_dec;
               if (cnt_dec == lo_r) begin
                  pass_cnt_nxt = pass_inc;
                  if (last_pass) begin
                     state_nxt = S_DONE;
                  end else if (dwell_r != '0) begin
                     state_nxt = S_HOLD_LO;
                     timer_nxt = dwell_r;
                  end else begin
                     state_nxt   = S_UP;
                     up_down_nxt = 1'b1;
                  end
               end
            end
         end
         S_HOLD_LO: begin
            if (stop) begin
               state_nxt = S_IDLE;
            end else if (timer_end) begin
               state_nxt   = S_UP;
               up_down_nxt = 1'b1;
               timer_nxt   = '0;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // status flags are decoded from the next state so they register in step with it
   always_comb begin
      busy_nxt = (state_nxt == S_UP) || (state_nxt == S_HOLD_HI) ||
                 (state_nxt == S_DOWN) || (state_nxt == S_HOLD_LO);
      done_nxt = (state_nxt == S_DONE);
      err_nxt  = reject;
   end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl; expected per-cycle outputs are queued from a sweep model.
module tb_updown_sweep_ctrl;
   localparam int WIDTH   = 4;
   localparam int PASS_W  = 4;
   localparam int DWELL_W = 4;

   logic               clk = 1'b0;
   logic               rst, start, stop;
   logic [WIDTH-1:0]   lo_lim, hi_lim;
   logic [DWELL_W-1:0] dwell;
   logic [PASS_W-1:0]  passes;
   logic [WIDTH-1:0]   count;
   logic               up_down, busy, done, err;
   logic [PASS_W-1:0]  pass_cnt;

   typedef struct packed {
      logic [3:0] c;
      logic       ud;
      logic       busy;
      logic       done;
      logic       err;
      logic [3:0] pc;
   } exp_t;

   exp_t q[$];
   exp_t last_e;
   int   checks = 0;
   int   errors = 0;

   updown_sweep_ctrl #(.WIDTH(WIDTH), .PASS_W(PASS_W), .DWELL_W(DWELL_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .lo_lim(lo_lim), .hi_lim(hi_lim), .dwell(dwell), .passes(passes),
      .count(count), .up_down(up_down), .busy(busy), .done(done), .err(err),
      .pass_cnt(pass_cnt)
   );

   always #5 clk = ~clk;

   function automatic string fmt(input exp_t e);
      return $sformatf("cnt=%0d ud=%0b busy=%0b done=%0b err=%0b pc=%0d",
                       e.c, e.ud, e.busy, e.done, e.err, e.pc);
   endfunction

   function automatic exp_t obs();
      return exp_t'({count, up_down, busy, done, err, pass_cnt});
   endfunction

   task automatic push(input int c, input logic ud, input logic b, input logic d, input logic [3:0] pc);
      exp_t e;
      e = exp_t'({4'(c), ud, b, d, 1'b0, pc});
      q.push_back(e);
      last_e = e;
   endtask

   // cycle-by-cycle picture of a sweep as seen after the start edge
   task automatic model_sweep(input int lo, input int hi, input int dw, input int np, input bit cont);
      logic [3:0] pc;
      pc = 4'd0;
      push(lo, 1'b1, 1'b1, 1'b0, pc);
      for (int p = 0; p < np; p++) begin
         for (int v = lo + 1; v < hi; v++) push(v, 1'b1, 1'b1, 1'b0, pc);
         for (int k = 0; k < dw; k++) push(hi, 1'b1, 1'b1, 1'b0, pc);
         push(hi, 1'b0, 1'b1, 1'b0, pc);
         for (int v = hi - 1; v > lo; v--) push(v, 1'b0, 1'b1, 1'b0, pc);
         pc = pc + 4'd1;
         if (!cont && p == np - 1) begin
            push(lo, 1'b0, 1'b0, 1'b1, pc);
            push(lo, 1'b0, 1'b0, 1'b0, pc);
         end else begin
            for (int k = 0; k < dw; k++) push(lo, 1'b0, 1'b1, 1'b0, pc);
            push(lo, 1'b1, 1'b1, 1'b0, pc);
         end
      end
   endtask

   task automatic kick(input int lo, input int hi, input int dw, input int ps, input logic stp);
      @(negedge clk);
      lo_lim = 4'(lo);
      hi_lim = 4'(hi);
      dwell  = 4'(dw);
      passes = 4'(ps);
      start  = 1'b1;
      stop   = stp;
   endtask

   // mode 0: drain; 1: assert stop on matching down-count item; 2: return on it
   task automatic run_q(input string name, input int mode, input int at_cnt, input bit poke);
      exp_t e, o;
      int   idx;
      idx = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         start = 1'b0;
         stop  = 1'b0;
         e = q.pop_front();
         o = obs();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s item %0d: got %s expected %s", name, idx, fmt(o), fmt(e));
         end
         if (poke && idx == 3) begin
            start  = 1'b1;
            lo_lim = 4'd0;
            hi_lim = 4'd15;
            dwell  = 4'd3;
            passes = 4'd5;
         end
         if (mode != 0 && e.busy && !e.ud && e.c == 4'(at_cnt)) begin
            if (mode == 1) stop = 1'b1;
            q.delete();
         end
         idx++;
      end
   endtask

   task automatic test_reset();
      exp_t o, e;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      lo_lim = '0; hi_lim = '0; dwell = '0; passes = '0;
      e = exp_t'({4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
      repeat (2) @(negedge clk);
      o = obs();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_held: got %s expected %s", fmt(o), fmt(e));
      end
      rst = 1'b0;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_release: got %s expected %s", fmt(o), fmt(e));
      end
      last_e = e;
   endtask

   task automatic test_single_pass();
      kick(2, 5, 0, 1, 1'b0);
      model_sweep(2, 5, 0, 1, 1'b0);
      run_q("single_pass", 0, 0, 1'b0);
   endtask

   task automatic test_err();
      exp_t o, e;
      int lo_t[2] = '{7, 9};
      int hi_t[2] = '{7, 4};
      for (int i = 0; i < 2; i++) begin
         e = last_e;
         @(negedge clk);
         lo_lim = 4'(lo_t[i]);
         hi_lim = 4'(hi_t[i]);
         start  = 1'b1;
         @(negedge clk);
         start = 1'b0;
         e.err = 1'b1;
         o = obs();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL err_pulse%0d: got %s expected %s", i, fmt(o), fmt(e));
         end
         @(negedge clk);
         e.err = 1'b0;
         o = obs();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL err_clear%0d: got %s expected %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_dwell();
      kick(0, 3, 2, 2, 1'b0);
      model_sweep(0, 3, 2, 2, 1'b0);
      run_q("dwell", 0, 0, 1'b0);
   endtask

   task automatic test_stop();
      exp_t o, e;
      kick(1, 6, 0, 3, 1'b0);
      model_sweep(1, 6, 0, 3, 1'b0);
      run_q("stop_run", 1, 4, 1'b0);
      e = exp_t'({4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         stop = 1'b0;
         o = obs();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stop_frozen%0d: got %s expected %s", i, fmt(o), fmt(e));
         end
      end
      kick(1, 6, 0, 1, 1'b0);
      model_sweep(1, 6, 0, 1, 1'b0);
      run_q("stop_restart", 0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      kick(2, 5, 0, 1, 1'b1);
      model_sweep(2, 5, 0, 1, 1'b0);
      run_q("start_stop_idle", 0, 0, 1'b1);
      kick(3, 4, 1, 1, 1'b0);
      model_sweep(3, 4, 1, 1, 1'b0);
      run_q("back_to_back", 0, 0, 1'b0);
   endtask

   task automatic test_async_reset();
      exp_t o, e;
      kick(0, 5, 0, 1, 1'b0);
      model_sweep(0, 5, 0, 1, 1'b0);
      run_q("pre_reset", 2, 3, 1'b0);
      #2 rst = 1'b1;
      #1;
      e = exp_t'({4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
      o = obs();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL async_reset: got %s expected %s", fmt(o), fmt(e));
      end
      #1 rst = 1'b0;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL after_reset: got %s expected %s", fmt(o), fmt(e));
      end
      last_e = e;
   endtask

   task automatic test_passes_zero();
      exp_t o, e;
      kick(0, 2, 0, 0, 1'b0);
`ifdef UPDOWN_SWEEP_CONT_EN
      model_sweep(0, 2, 0, 20, 1'b1);
      run_q("continuous", 0, 0, 1'b0);
      stop = 1'b1;
      e = last_e;
      e.busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stop = 1'b0;
         o = obs();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL cont_stop%0d: got %s expected %s", i, fmt(o), fmt(e));
         end
      end
`else
      model_sweep(0, 2, 0, 1, 1'b0);
      run_q("passes_zero", 0, 0, 1'b0);
      e = last_e;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL passes_zero_idle: got %s expected %s", fmt(o), fmt(e));
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_err();
      test_dwell();
      test_stop();
      test_back_to_back();
      test_async_reset();
      test_passes_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
